// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the load/store unit.
//   lsu_funct3_e  : RISC-V load/store width encodings (funct3).
//   lsu_state_e   : control FSM states.
//   lsu_access_ok : legality and alignment check applied when a request is accepted.
package lsu_pkg;

   typedef enum logic [2:0] {
      LSU_B  = 3'b000,
      LSU_H  = 3'b001,
      LSU_W  = 3'b010,
      LSU_BU = 3'b100,
      LSU_HU = 3'b101
   } lsu_funct3_e;

   typedef enum logic {
      ST_IDLE      = 1'b0,
      ST_RMW_WRITE = 1'b1
   } lsu_state_e;

   // Returns 1 when the access is legal: known funct3, no unsigned store, natural alignment.
   function automatic logic lsu_access_ok(input logic store,
                                          input logic [2:0] funct3,
                                          input logic [1:0] lane);
      logic ok;
      case (funct3)
         LSU_B:   ok = 1'b1;
         LSU_H:   ok = ~lane[0];
         LSU_W:   ok = (lane == 2'b00);
         LSU_BU:  ok = ~store;
         LSU_HU:  ok = ~store & ~lane[0];
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: core request/response and data-memory signals of the load/store unit.
//   slave  : the load/store unit side (drives ready, response and memory controls).
//   master : the environment side (core + data memory).
interface load_store_unit_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8
);
   logic                    req_valid;
   logic                    req_ready;
   logic                    req_store;
   logic [2:0]              req_funct3;
   logic [ADDR_WIDTH+1:0]   req_addr;
   logic [DATA_WIDTH-1:0]   req_wdata;
   logic                    resp_valid;
   logic [DATA_WIDTH-1:0]   resp_rdata;
   logic                    resp_error;
   logic [ADDR_WIDTH-1:0]   mem_addr;
   logic                    mem_read_en;
   logic                    mem_write_en;
   logic [DATA_WIDTH-1:0]   mem_write_data;
   logic [DATA_WIDTH-1:0]   mem_read_data;

   modport slave (
      input  req_valid, req_store, req_funct3, req_addr, req_wdata, mem_read_data,
      output req_ready, resp_valid, resp_rdata, resp_error,
             mem_addr, mem_read_en, mem_write_en, mem_write_data
   );

   modport master (
      output req_valid, req_store, req_funct3, req_addr, req_wdata, mem_read_data,
      input  req_ready, resp_valid, resp_rdata, resp_error,
             mem_addr, mem_read_en, mem_write_en, mem_write_data
   );
endinterface

// File: rtl/lsu_lane.sv
// lsu_lane: combinational byte-lane logic of the load/store unit.
//   funct3     in  access width / signedness
//   lane       in  byte offset within the word (addr[1:0])
//   rd_word    in  word read from memory
//   wr_data    in  store data (low byte/half used for sub-word stores)
//   load_data  out extracted and sign/zero-extended load result
//   merge_data out rd_word with the addressed byte/half replaced by wr_data
module lsu_lane
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  lane,
   input  logic [31:0] rd_word,
   input  logic [31:0] wr_data,
   output logic [31:0] load_data,
   output logic [31:0] merge_data
);

   logic [31:0] shifted_s;

   // Load path: bring the addressed lane down to bit 0, then extend.
   always_comb begin
      shifted_s = rd_word >> {lane, 3'b000};
      case (funct3)
         LSU_B:   load_data = {{24{shifted_s[7]}}, shifted_s[7:0]};
         LSU_H:   load_data = {{16{shifted_s[15]}}, shifted_s[15:0]};
         LSU_W:   load_data = rd_word;
         LSU_BU:  load_data = {24'h000000, shifted_s[7:0]};
         LSU_HU:  load_data = {16'h0000, shifted_s[15:0]};
         default: load_data = 32'h00000000;
      endcase
   end

   // Store path: splice the new byte/half into the word just read.
   always_comb begin
      merge_data = wr_data;
      case (funct3[1:0])
         2'b00: begin
            case (lane)
               2'b00:   merge_data = {rd_word[31:8], wr_data[7:0]};
               2'b01:   merge_data = {rd_word[31:16], wr_data[7:0], rd_word[7:0]};
               2'b10:   merge_data = {rd_word[31:24], wr_data[7:0], rd_word[15:0]};
               2'b11:   merge_data = {wr_data[7:0], rd_word[23:0]};
               default: merge_data = rd_word;
            endcase
         end
         2'b01: begin
            if (lane[1]) begin
               merge_data = {wr_data[15:0], rd_word[15:0]};
            end else begin
               merge_data = {rd_word[31:16], wr_data[15:0]};
            end
         end
         default: merge_data = wr_data;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: byte-addressed RISC-V loads/stores onto a word-addressed memory
// without byte enables. Sub-word stores use a read-modify-write over two cycles.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : request/response and data-memory signals (slave modport)
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8
) (
   input logic              clk,
   input logic              rst,
   load_store_unit_if.slave bus
);

   if (DATA_WIDTH != 32) begin : g_width_check
      $error("load_store_unit: only DATA_WIDTH = 32 is supported");
   end

   lsu_state_e            state_q, state_d;
   logic                  resp_valid_q, resp_valid_d;
   logic                  resp_error_q, resp_error_d;
   logic [31:0]           resp_rdata_q, resp_rdata_d;
   logic [ADDR_WIDTH-1:0] rmw_addr_q, rmw_addr_d;
   logic [31:0]           rmw_data_q, rmw_data_d;

   logic        ready_s, accept_s, legal_s, go_s, is_word_s, sub_store_s;
   logic [31:0] load_data_s, merge_data_s;

   lsu_lane u_lane (
      .funct3     (bus.req_funct3),
      .lane       (bus.req_addr[1:0]),
      .rd_word    (bus.mem_read_data),
      .wr_data    (bus.req_wdata),
      .load_data  (load_data_s),
      .merge_data (merge_data_s)
   );

   // Request qualification.
   always_comb begin
      ready_s     = (state_q == ST_IDLE) && !rst;
      accept_s    = bus.req_valid && ready_s;
      legal_s     = lsu_access_ok(bus.req_store, bus.req_funct3, bus.req_addr[1:0]);
      go_s        = accept_s && legal_s;
      is_word_s   = (bus.req_funct3 == LSU_W);
      sub_store_s = go_s && bus.req_store && !is_word_s;
   end

   // Memory controls; in RMW_WRITE only the latched address/merged word are used,
   // so mem_read_data never reaches mem_write_data combinationally.
   always_comb begin
      if (state_q == ST_RMW_WRITE) begin
         bus.mem_addr       = rmw_addr_q;
         bus.mem_write_data = rmw_data_q;
         bus.mem_read_en    = 1'b0;
         bus.mem_write_en   = !rst;
      end else begin
         bus.mem_addr       = bus.req_addr[ADDR_WIDTH+1:2];
         bus.mem_write_data = bus.req_wdata;
         bus.mem_read_en    = go_s && (!bus.req_store || !is_word_s);
         bus.mem_write_en   = go_s && bus.req_store && is_word_s;
      end
   end

   // Next-state and response computation.
   always_comb begin
      state_d      = state_q;
      resp_valid_d = 1'b0;
      resp_error_d = 1'b0;
      resp_rdata_d = 32'h00000000;
      rmw_addr_d   = rmw_addr_q;
      rmw_data_d   = rmw_data_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s && !legal_s) begin
               resp_valid_d = 1'b1;
               resp_error_d = 1'b1;
            end else if (sub_store_s) begin
               state_d    = ST_RMW_WRITE;
               rmw_addr_d = bus.req_addr[ADDR_WIDTH+1:2];
               rmw_data_d = merge_data_s;
            end else if (go_s) begin
               resp_valid_d = 1'b1;
               resp_rdata_d = bus.req_store ? 32'h00000000 : load_data_s;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RMW_WRITE: begin
            state_d      = ST_IDLE;
            resp_valid_d = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and registered response.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         resp_valid_q <= 1'b0;
         resp_error_q <= 1'b0;
         resp_rdata_q <= 32'h00000000;
         rmw_addr_q   <= '0;
         rmw_data_q   <= 32'h00000000;
      end else begin
         state_q      <= state_d;
         resp_valid_q <= resp_valid_d;
         resp_error_q <= resp_error_d;
         resp_rdata_q <= resp_rdata_d;
         rmw_addr_q   <= rmw_addr_d;
         rmw_data_q   <= rmw_data_d;
      end
   end

   assign bus.req_ready  = ready_s;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_error = resp_error_q;
   assign bus.resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: random and directed stimulus against a behavioural model
// (reference memory plus per-cycle expectation tables) for load_store_unit.
module tb_load_store_unit;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   load_store_unit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus ();

   load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // ---------------- data memory ----------------
   logic [31:0] mem [256];
   logic        pre_we = 1'b0;
   logic [7:0]  pre_addr = 8'h00;
   logic [31:0] pre_data = 32'h0;
   assign bus.mem_read_data = mem[bus.mem_addr];
   always @(posedge clk) begin
      if (pre_we) mem[pre_addr] <= pre_data;
      else if (bus.mem_write_en) mem[bus.mem_addr] <= bus.mem_write_data;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- bookkeeping ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [31:0] ref_mem [256];
   bit          exp_rv   [int];
   bit          exp_err  [int];
   logic [31:0] exp_rd   [int];
   bit          exp_re   [int];
   logic [7:0]  exp_ra   [int];
   bit          exp_we   [int];
   logic [7:0]  exp_wa   [int];
   logic [31:0] exp_wd   [int];
   bit          exp_busy [int];
   bit          model_on = 1'b0;

   function automatic int access_size(input logic [2:0] f3);
      if (f3 == 3'd0 || f3 == 3'd4) return 1;
      if (f3 == 3'd1 || f3 == 3'd5) return 2;
      return 4;
   endfunction

   function automatic bit model_legal(input bit st, input logic [2:0] f3, input logic [9:0] a);
      if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b0;
      if (st && f3 >= 3'd4) return 1'b0;
      return (int'(a) % access_size(f3)) == 0;
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [9:0] a);
      logic [31:0] w, v;
      w = ref_mem[a[9:2]];
      v = w >> (int'(a[1:0]) * 8);
      case (f3)
         3'd0: begin v = v & 32'hFF;   if (v > 32'd127)   v = v | 32'hFFFFFF00; end
         3'd1: begin v = v & 32'hFFFF; if (v > 32'd32767) v = v | 32'hFFFF0000; end
         3'd4: v = v & 32'hFF;
         3'd5: v = v & 32'hFFFF;
         default: v = w;
      endcase
      return v;
   endfunction

   task automatic model_accept(input int c, input bit st, input logic [2:0] f3,
                               input logic [9:0] a, input logic [31:0] wd);
      logic [7:0]  wa;
      logic [31:0] mask, old;
      int          sh;
      wa = a[9:2];
      if (!model_legal(st, f3, a)) begin
         exp_rv[c+1] = 1'b1; exp_err[c+1] = 1'b1; exp_rd[c+1] = 32'h0;
      end else if (!st) begin
         exp_re[c] = 1'b1; exp_ra[c] = wa;
         exp_rv[c+1] = 1'b1; exp_err[c+1] = 1'b0; exp_rd[c+1] = model_load(f3, a);
      end else if (access_size(f3) == 4) begin
         exp_we[c] = 1'b1; exp_wa[c] = wa; exp_wd[c] = wd;
         ref_mem[wa] = wd;
         exp_rv[c+1] = 1'b1; exp_err[c+1] = 1'b0; exp_rd[c+1] = 32'h0;
      end else begin
         sh   = int'(a[1:0]) * 8;
         mask = ((access_size(f3) == 1) ? 32'hFF : 32'hFFFF) << sh;
         old  = ref_mem[wa];
         exp_re[c] = 1'b1; exp_ra[c] = wa;
         exp_busy[c+1] = 1'b1;
         exp_we[c+1] = 1'b1; exp_wa[c+1] = wa;
         exp_wd[c+1] = (old & ~mask) | ((wd << sh) & mask);
         ref_mem[wa] = exp_wd[c+1];
         exp_rv[c+2] = 1'b1; exp_err[c+2] = 1'b0; exp_rd[c+2] = 32'h0;
      end
   endtask

   // Compare process: every cycle while the model is tracking.
   initial forever begin
      @(negedge clk);
      if (model_on) begin
         check32("resp_valid", {31'd0, bus.resp_valid}, {31'd0, exp_rv.exists(cyc)});
         if (exp_rv.exists(cyc)) begin
            check32("resp_error", {31'd0, bus.resp_error}, {31'd0, exp_err[cyc]});
            check32("resp_rdata", bus.resp_rdata, exp_rd[cyc]);
         end
         check32("req_ready", {31'd0, bus.req_ready}, {31'd0, !exp_busy.exists(cyc)});
         check32("mem_read_en", {31'd0, bus.mem_read_en}, {31'd0, exp_re.exists(cyc)});
         if (exp_re.exists(cyc)) check32("mem_addr_rd", {24'd0, bus.mem_addr}, {24'd0, exp_ra[cyc]});
         check32("mem_write_en", {31'd0, bus.mem_write_en}, {31'd0, exp_we.exists(cyc)});
         if (exp_we.exists(cyc)) begin
            check32("mem_addr_wr", {24'd0, bus.mem_addr}, {24'd0, exp_wa[cyc]});
            check32("mem_write_data", bus.mem_write_data, exp_wd[cyc]);
         end
      end
   end

   // Drive one cycle of request inputs; the model sees it only if it would be accepted.
   task automatic drive(input bit v, input bit st, input logic [2:0] f3,
                        input logic [9:0] a, input logic [31:0] wd);
      bus.req_valid  = v;
      bus.req_store  = st;
      bus.req_funct3 = f3;
      bus.req_addr   = a;
      bus.req_wdata  = wd;
      if (v && !exp_busy.exists(cyc)) model_accept(cyc, st, f3, a, wd);
      @(posedge clk); #1;
   endtask

   // Reset-abort watcher.
   bit watch = 1'b0;
   int rv_seen = 0;
   int we_seen = 0;
   initial forever begin
      @(posedge clk);
      if (watch) begin
         if (bus.resp_valid) rv_seen++;
         if (bus.mem_write_en) we_seen++;
      end
   end

   initial begin
      int          c;
      logic [31:0] d, save8;
      bit          v, st;
      logic [2:0]  f3;
      logic [9:0]  a;

      bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_funct3 = 3'd0;
      bus.req_addr = 10'h0; bus.req_wdata = 32'h0;

      // Preload memory (unit held in reset).
      @(posedge clk); #1;
      for (int i = 0; i < 256; i++) begin
         d = $urandom;
         if (i == 5) d = 32'h8899AABB;
         if (i == 8) d = 32'h11223344;
         pre_we = 1'b1; pre_addr = 8'(i); pre_data = d; ref_mem[i] = d;
         @(posedge clk); #1;
      end
      pre_we = 1'b0;

      // Reset state, with a request offered to show it is ignored.
      bus.req_valid = 1'b1; bus.req_funct3 = 3'd2; bus.req_addr = 10'h014;
      #1;
      check32("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
      check32("rst_mem_read_en", {31'd0, bus.mem_read_en}, 32'd0);
      check32("rst_mem_write_en", {31'd0, bus.mem_write_en}, 32'd0);
      check32("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
      check32("rst_resp_rdata", bus.resp_rdata, 32'd0);
      check32("rst_resp_error", {31'd0, bus.resp_error}, 32'd0);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      rst = 1'b0;
      model_on = 1'b1;
      drive(1'b0, 1'b0, 3'd0, 10'h0, 32'h0);

      // Loads of word 5 = 0x8899AABB.
      c = cyc; drive(1'b1, 1'b0, 3'd0, 10'h015, 32'h0);
      check32("pin_lb", exp_rd[c+1], 32'hFFFFFFAA);
      c = cyc; drive(1'b1, 1'b0, 3'd4, 10'h015, 32'h0);
      check32("pin_lbu", exp_rd[c+1], 32'h000000AA);
      c = cyc; drive(1'b1, 1'b0, 3'd1, 10'h016, 32'h0);
      check32("pin_lh", exp_rd[c+1], 32'hFFFF8899);
      c = cyc; drive(1'b1, 1'b0, 3'd2, 10'h014, 32'h0);
      check32("pin_lw", exp_rd[c+1], 32'h8899AABB);

      // SB 0x5A at 0x17; a second request offered in the busy cycle must be ignored.
      c = cyc; drive(1'b1, 1'b1, 3'd0, 10'h017, 32'h0000005A);
      check32("pin_sb_data", exp_wd[c+1], 32'h5A99AABB);
      drive(1'b1, 1'b0, 3'd2, 10'h000, 32'h0);
      drive(1'b0, 1'b0, 3'd0, 10'h0, 32'h0);

      // Illegal accesses.
      c = cyc; drive(1'b1, 1'b1, 3'd1, 10'h015, 32'h00001234);
      check32("pin_sh_err", {31'd0, exp_err[c+1]}, 32'd1);
      c = cyc; drive(1'b1, 1'b1, 3'd2, 10'h00D, 32'h0);
      check32("pin_sw_err", {31'd0, exp_err[c+1]}, 32'd1);
      c = cyc; drive(1'b1, 1'b0, 3'd3, 10'h010, 32'h0);
      check32("pin_f3_err", {31'd0, exp_err[c+1]}, 32'd1);

      // Back-to-back LW / SW / LW.
      c = cyc;
      drive(1'b1, 1'b0, 3'd2, 10'h000, 32'h0);
      drive(1'b1, 1'b1, 3'd2, 10'h004, 32'hDEADBEEF);
      drive(1'b1, 1'b0, 3'd2, 10'h004, 32'h0);
      check32("pin_b2b", exp_rd[c+3], 32'hDEADBEEF);

      // Random traffic.
      for (int i = 0; i < 1500; i++) begin
         v  = ($urandom_range(3) != 0);
         st = $urandom_range(1);
         f3 = ($urandom_range(7) == 0) ? 3'($urandom_range(7)) : 3'($urandom_range(5));
         if (f3 == 3'd3) f3 = 3'd4;
         a  = 10'($urandom);
         if ($urandom_range(1) == 1) a = a & ~10'(access_size(f3) - 1);
         drive(v, st, f3, a, $urandom);
      end
      repeat (3) drive(1'b0, 1'b0, 3'd0, 10'h0, 32'h0);
      for (int i = 0; i < 256; i++) check32("mem_word", mem[i], ref_mem[i]);
      model_on = 1'b0;

      // Reset during RMW_WRITE of SB at 0x20.
      save8 = mem[8];
      bus.req_valid = 1'b1; bus.req_store = 1'b1; bus.req_funct3 = 3'd0;
      bus.req_addr = 10'h020; bus.req_wdata = 32'h00000077;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      check32("rmw_req_ready", {31'd0, bus.req_ready}, 32'd0);
      check32("rmw_write_en", {31'd0, bus.mem_write_en}, 32'd1);
      watch = 1'b1;
      rst = 1'b1;
      #1;
      check32("abort_write_en", {31'd0, bus.mem_write_en}, 32'd0);
      check32("abort_req_ready", {31'd0, bus.req_ready}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      check32("post_rst_ready", {31'd0, bus.req_ready}, 32'd1);
      repeat (3) @(posedge clk);
      #1;
      watch = 1'b0;
      check32("abort_resp_count", rv_seen, 32'd0);
      check32("abort_write_count", we_seen, 32'd0);
      check32("abort_word8", mem[8], save8);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sits between the core's memory stage and the word-addressed `data_memory`. Converts RISC-V byte-addressed load/store requests (B/H/W, signed/unsigned) into word-wide memory accesses. Extracts and sign- or zero-extends loaded data. Performs read-modify-write for sub-word stores, since the memory has no byte enables. Rejects misaligned or illegal accesses with an error response and no memory side effect.

## Interface
- `DATA_WIDTH`, 32, word width; only 32 is supported (elaboration error otherwise).
- `ADDR_WIDTH`, 8, word-address width of the data memory; the byte address is `ADDR_WIDTH+2` bits.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block accepts a request this cycle.
- `req_store`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `req_addr`  in  ADDR_WIDTH+2  byte address.
- `req_wdata`  in  DATA_WIDTH  store data; the low bytes are used for B/H.
- `resp_valid`  out  1  one-cycle completion pulse; cannot be stalled.
- `resp_rdata`  out  DATA_WIDTH  extended load data; 0 for stores and errors.
- `resp_error`  out  1  misaligned or illegal access, qualified by `resp_valid`.
- `mem_addr`  out  ADDR_WIDTH  word address, equal to `req_addr[ADDR_WIDTH+1:2]` (or the latched copy).
- `mem_read_en`  out  1  memory read enable.
- `mem_write_en`  out  1  memory write enable; the write happens on the next rising edge.
- `mem_write_data`  out  DATA_WIDTH  full word to write.
- `mem_read_data`  in  DATA_WIDTH  combinational read data, valid in the same cycle as `mem_read_en`.

## Operation
- States: IDLE, RMW_WRITE.
- `req_ready` = (state == IDLE) and not `rst`. A request is accepted when `req_valid && req_ready`.

Legality checks, applied at acceptance:
- funct3 011/110/111 is illegal.
- A store with funct3 100/101 is illegal.
- H/HU with `addr[0]`=1 is misaligned.
- W with `addr[1:0]`≠0 is misaligned.
- On any of these: no memory enable asserts. Next cycle `resp_valid`=1, `resp_error`=1, `resp_rdata`=0.

Load (IDLE):
- `mem_read_en`=1 combinationally.
- The selected lane is extracted using `addr[1:0]`. B/H are sign-extended; BU/HU are zero-extended.
- The result is registered into `resp_rdata`; `resp_valid` follows next cycle.

Word store (IDLE):
- `mem_write_en`=1 with `mem_write_data`=`req_wdata`.
- `resp_valid` next cycle. State stays IDLE.

Sub-word store:
- IDLE: `mem_read_en`=1. The block latches word address, merged word (read word with the target byte/half lane replaced by `req_wdata[7:0]`/`[15:0]`), and goes to RMW_WRITE.
- RMW_WRITE: `mem_write_en`=1, `mem_addr` from the latch, `mem_write_data` from the merge register only. Return to IDLE; `resp_valid` next cycle.
- No combinational path from `mem_read_data` to `mem_write_data`.

Other rules:
- `mem_read_en` and `mem_write_en` are never both high.
- Enables are 0 whenever no request is accepted and the state is not RMW_WRITE.

## Timing
- Reset values: state IDLE, `resp_valid`=0, `resp_rdata`=0, `resp_error`=0, merge/address latches 0.
- While `rst`=1: `req_ready`=0, `mem_read_en`=0, `mem_write_en`=0.
- Latency from acceptance edge to `resp_valid`:
  - load 1 cycle;
  - word store 1 cycle;
  - sub-word store 2 cycles;
  - error 1 cycle.
- Throughput: one load or word store per cycle back-to-back. `req_ready`=0 during RMW_WRITE.
- Reset asserted in RMW_WRITE: the state goes IDLE asynchronously and `mem_write_en` drops before the next edge. No write occurs and no response is issued.
- Lane wrap: the byte lane is `addr[1:0]` only. No access crosses a word boundary, because misaligned accesses are rejected.

## Structure
- `lsu_pkg`:
  - `funct3` enum (`LSU_B`, `LSU_H`, `LSU_W`, `LSU_BU`, `LSU_HU`);
  - state enum;
  - a legality/alignment check function.
- Sub-module `lsu_lane`: purely combinational. It holds load extract/extend and store lane merge, and is instantiated once in `load_store_unit`.

## Test plan
- Memory word 5 = 0x8899AABB, loads:
  - LB at 0x15 -> `resp_rdata`=0xFFFFFFAA;
  - LBU at 0x15 -> 0x000000AA;
  - LH at 0x16 -> 0xFFFF8899;
  - LW at 0x14 -> 0x8899AABB;
  - each with `resp_valid` 1 cycle later.
- SB 0x5A at 0x17 (word 5 = 0x8899AABB):
  - `req_ready` low for 1 cycle;
  - single write 0x5A99AABB to word 5;
  - `resp_valid` 2 cycles after acceptance.
- SH 0x1234 at 0x15, SW 0x0 at 0x0D, funct3 011 load at 0x10:
  - each gives `resp_error`=1, `resp_rdata`=0;
  - memory unchanged; no enable asserted.
- Back-to-back: LW 0x00, SW 0xDEADBEEF at 0x04, LW 0x04 on consecutive cycles:
  - three responses on consecutive cycles;
  - third returns 0xDEADBEEF.
- `rst` pulsed while in RMW_WRITE of SB at 0x20:
  - no `mem_write_en` edge, word 8 unchanged;
  - no `resp_valid`;
  - `req_ready`=1 the cycle after `rst` deasserts.
